// File: rtl/hazard_unit.sv
// ID/EX pipeline control: load-use, redirect and memory-wait hazard resolution,
// EX-stage operand forwarding selects, and saturating debug event counters.
module hazard_unit #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] inst_ID,
    input  logic [Width-1:0] inst_EX,
    input  logic             RegWEn_EX,
    input  logic [1:0]       WBSel_EX,
    input  logic             PCSel_EX,
    input  logic [Width-1:0] inst_MEM,
    input  logic             RegWEn_MEM,
    input  logic [Width-1:0] inst_WB,
    input  logic             RegWEn_WB,
    input  logic             mem_stall_i,
    output logic             stall_pc_o,
    output logic             stall_ifid_o,
    output logic             bubble_idex_o,
    output logic             hold_idex_o,
    output logic             flush_ifid_o,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic [Width-1:0] bubble_cnt_o,
    output logic [Width-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LU_BUBBLE = 2'b01,
        MEM_HOLD  = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [Width-1:0] bubble_cnt_reg, bubble_cnt_next;
    logic [Width-1:0] flush_cnt_reg, flush_cnt_next;

    logic [4:0] rs1_id, rs2_id, rd_ex, rs1_ex, rs2_ex, rd_mem, rd_wb;
    logic [6:0] op_id, op_ex;
    logic       rs1_used_id, rs2_used_id, rs1_used_ex, rs2_used_ex;
    logic       load_use;

    logic stall_c, bubble_c, hold_c, flush_c, bubble_inc, flush_inc;
    logic [1:0] fwd_a_c, fwd_b_c;

    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_ID[Width-1:25], inst_ID[14:7],
                                inst_EX[Width-1:25], inst_EX[14:12],
                                inst_MEM[Width-1:12], inst_MEM[6:0],
                                inst_WB[Width-1:12], inst_WB[6:0]};

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    assign op_id  = inst_ID[6:0];
    assign rs1_id = inst_ID[19:15];
    assign rs2_id = inst_ID[24:20];
    assign op_ex  = inst_EX[6:0];
    assign rd_ex  = inst_EX[11:7];
    assign rs1_ex = inst_EX[19:15];
    assign rs2_ex = inst_EX[24:20];
    assign rd_mem = inst_MEM[11:7];
    assign rd_wb  = inst_WB[11:7];

    assign rs1_used_id = uses_rs1(op_id);
    assign rs2_used_id = uses_rs2(op_id);
    assign rs1_used_ex = uses_rs1(op_ex);
    assign rs2_used_ex = uses_rs2(op_ex);

    assign load_use = RegWEn_EX && (WBSel_EX == 2'b00) && (rd_ex != 5'd0) &&
                      ((rs1_used_id && rd_ex == rs1_id) ||
                       (rs2_used_id && rd_ex == rs2_id));

    // x0 is excluded up front, so the rd!=0 checks fold into rs!=0.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                           input logic wen_mem, input logic [4:0] rdm,
                                           input logic wen_wb, input logic [4:0] rdw);
        if (!used || rs == 5'd0)      return 2'b00;
        else if (wen_mem && rdm == rs) return 2'b01;
        else if (wen_wb && rdw == rs)  return 2'b10;
        else                           return 2'b00;
    endfunction

    assign fwd_a_c = fwd_sel(rs1_ex, rs1_used_ex, RegWEn_MEM, rd_mem, RegWEn_WB, rd_wb);
    assign fwd_b_c = fwd_sel(rs2_ex, rs2_used_ex, RegWEn_MEM, rd_mem, RegWEn_WB, rd_wb);

    always_comb begin
        state_next = RUN;
        stall_c    = 1'b0;
        bubble_c   = 1'b0;
        hold_c     = 1'b0;
        flush_c    = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        if (PCSel_EX) begin
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            flush_inc = 1'b1;
        end else if (mem_stall_i) begin
            stall_c    = 1'b1;
            hold_c     = 1'b1;
            state_next = MEM_HOLD;
        end else if (load_use) begin
            // A repeat hazard while EX already holds our bubble is not a new event.
            stall_c    = 1'b1;
            bubble_c   = 1'b1;
            bubble_inc = (state_reg != LU_BUBBLE);
            state_next = LU_BUBBLE;
        end
    end

    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        flush_cnt_next  = flush_cnt_reg;
        if (bubble_inc && bubble_cnt_reg != {Width{1'b1}})
            bubble_cnt_next = bubble_cnt_reg + Width'(1);
        if (flush_inc && flush_cnt_reg != {Width{1'b1}})
            flush_cnt_next = flush_cnt_reg + Width'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= RUN;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            bubble_cnt_reg <= bubble_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign stall_pc_o    = rst_ni & stall_c;
    assign stall_ifid_o  = rst_ni & stall_c;
    assign bubble_idex_o = rst_ni & bubble_c;
    assign hold_idex_o   = rst_ni & hold_c;
    assign flush_ifid_o  = rst_ni & flush_c;
    assign fwdA_o        = rst_ni ? fwd_a_c : 2'b00;
    assign fwdB_o        = rst_ni ? fwd_b_c : 2'b00;
    assign bubble_cnt_o  = bubble_cnt_reg;
    assign flush_cnt_o   = flush_cnt_reg;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Control end of the ID/EX pipeline register. It decides, every cycle, whether the register loads, holds, or captures a bubble, and whether the IF/ID and ID/EX stages are squashed.
- Detects load-use hazards (ID consumer against EX load), branch/jump redirects (PCSel_EX), and external memory wait. It drives stall/bubble/flush controls into the IF, IF/ID and ID/EX stages.
- Also produces EX-stage operand forwarding selects and keeps saturating bubble/flush event counters for debug.

Parameters:
- Width, 32, instruction/data width; counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- inst_ID  in  Width  instruction in ID.
- inst_EX  in  Width  instruction in EX.
- RegWEn_EX  in  1  EX instruction writes rd.
- WBSel_EX  in  2  EX writeback select; 2'b00 = load data.
- PCSel_EX  in  1  EX redirect taken (branch taken / jump).
- inst_MEM  in  Width  instruction in MEM.
- RegWEn_MEM  in  1  MEM instruction writes rd.
- inst_WB  in  Width  instruction in WB.
- RegWEn_WB  in  1  WB instruction writes rd.
- mem_stall_i  in  1  data memory not ready; freeze the whole pipe.
- stall_pc_o  out  1  hold PC.
- stall_ifid_o  out  1  hold IF/ID.
- bubble_idex_o  out  1  ID/EX loads all-zero controls/inst (NOP).
- hold_idex_o  out  1  ID/EX keeps its current contents.
- flush_ifid_o  out  1  IF/ID loads NOP.
- fwdA_o  out  2  rs1 select in EX: 00 regfile, 01 MEM, 10 WB.
- fwdB_o  out  2  rs2 select in EX, same encoding.
- bubble_cnt_o  out  Width  load-use bubbles inserted, saturating.
- flush_cnt_o  out  Width  redirect flushes, saturating.

Behaviour:
- Fields: rd = [11:7], rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
- rs1 is used unless opcode is 0110111, 0010111 or 1101111.
- rs2 is used only for opcode 0110011, 0100011 or 1100011.
- Register x0 never creates a hazard and is never forwarded.
- load_use = RegWEn_EX and WBSel_EX==2'b00 and rd_EX!=0 and (rd_EX==used rs1_ID or rd_EX==used rs2_ID).
- FSM states: RUN, LU_BUBBLE, MEM_HOLD, encoded in 2 bits. Reset state is RUN.
- Per-cycle priority: reset > PCSel_EX > mem_stall_i > load_use.
- PCSel_EX=1, any state: flush_ifid_o=1 and bubble_idex_o=1. All stalls and holds are 0, even if mem_stall_i or load_use is also 1. flush_cnt increments. Next state is RUN.
- Otherwise, mem_stall_i=1: stall_pc_o, stall_ifid_o and hold_idex_o are 1; bubble and flush are 0. Next state is MEM_HOLD. Counters unchanged.
- Otherwise, load_use=1 in RUN or MEM_HOLD: stall_pc_o, stall_ifid_o and bubble_idex_o are 1. bubble_cnt increments. Next state is LU_BUBBLE.
- LU_BUBBLE: EX holds the bubble, so load_use is structurally 0.
  - If load_use is nonetheless 1 (illegal), assert stall and bubble again, with no counter increment and no assertion failure.
  - Otherwise all controls are 0; next state is RUN.
- Otherwise: all stall/bubble/hold/flush outputs 0; next state is RUN.
- MEM_HOLD with mem_stall_i=0 re-evaluates load_use in that same cycle. There is no extra dead cycle.
- Stall/flush outputs are combinational from the registered state plus the current inputs. Latency is 0, same cycle.
- Forwarding is combinational, for used rs1/rs2 of inst_EX:
  - MEM match: RegWEn_MEM and rd_MEM!=0 and rd_MEM==rs → 01.
  - Else WB match, same condition on WB → 10.
  - Else → 00.
  - MEM wins over WB.
  - An unused operand field gives 00.
- Counters are registered and saturate at all-ones; no wrap.
- Asynchronous reset: state RUN, both counters 0. While rst_ni=0, all stall/bubble/hold/flush/fwd outputs are forced to 0.
- Reset deassertion in the middle of a stall resumes in RUN on the first clock edge.

Test Plan:
- lw x5,0(x1) in EX (RegWEn_EX=1, WBSel_EX=00); add x6,x5,x2 in ID → that cycle stall_pc/stall_ifid/bubble=1, state LU_BUBBLE. Next cycle all controls 0. bubble_cnt=1.
- Same load, ID=lui x5,0x1 (rs fields unused) → no stall. Load with rd=x0 and ID consumer using x0 → no stall.
- PCSel_EX=1 together with load_use=1 and mem_stall_i=1 → flush_ifid=1, bubble=1, stall/hold=0. flush_cnt increments by 1, bubble_cnt unchanged.
- mem_stall_i high for 3 cycles while load_use=1 → hold_idex/stall asserted 3 cycles, bubble=0. On the 4th cycle the bubble is asserted and bubble_cnt=1.
- EX add x3,x7,x7; MEM and WB both write x7 → fwdA=fwdB=01. Clear RegWEn_MEM → 10. WB rd=x0 → 00.
- Force bubble_cnt to all-ones, trigger load_use → stays 0xFFFFFFFF. Pull rst_ni low mid-LU_BUBBLE, asynchronously → outputs 0 immediately, counters 0, state RUN.
